// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, LEN*4
//             payload bytes LSB first, CSUM = XOR of payload), assembles
//             little-endian 32-bit words and writes them into instruction
//             memory. Holds the CPU in reset until a frame completes with
//             a matching checksum.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             rx_valid/rx_data    - incoming byte stream (valid/ready)
//             rx_ready            - loader accepts a byte this cycle
//             reload              - abort/restart loading, re-hold the CPU
//             imem_we/waddr/wdata - single-cycle instruction-memory write
//             cpu_hold            - CPU reset, high until a program is loaded
//             done / error        - frame accepted / frame rejected
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t             state_q;
    logic [7:0]         len_lo_q;
    logic [IDX_W-1:0]   last_idx_q;     // index of the final payload word
    logic [IDX_W-1:0]   word_idx_q;
    logic [1:0]         byte_cnt_q;
    logic [7:0]         xor_q;
    logic [23:0]        shift_q;        // lower three bytes of the word in flight
    logic               imem_we_q;
    logic [31:0]        imem_waddr_q;
    logic [31:0]        imem_wdata_q;
    logic               cpu_hold_q;
    logic               done_q;
    logic               error_q;

    logic               w_accept;
    logic [15:0]        w_len;
    logic               w_len_too_big;
    logic [IDX_W-1:0]   word_idx_d;
    logic [31:0]        w_waddr;

    assign rx_ready      = (state_q != S_DONE) && (state_q != S_ERROR);
    // A byte offered alongside reload is dropped.
    assign w_accept      = rx_valid && rx_ready && !reload;
    assign w_len         = {rx_data, len_lo_q};
    assign w_len_too_big = (32'(w_len) > 32'(DEPTH_WORDS));
    assign word_idx_d    = (word_idx_q == IDX_W'(DEPTH_WORDS - 1)) ? '0
                                                                   : word_idx_q + IDX_W'(1);
    assign w_waddr       = BASE_ADDR + 32'({word_idx_q, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            last_idx_q   <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            xor_q        <= '0;
            shift_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (reload) begin
                state_q    <= S_IDLE;
                word_idx_q <= '0;
                byte_cnt_q <= '0;
                xor_q      <= '0;
                cpu_hold_q <= 1'b1;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
            end else if (w_accept) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo_q <= rx_data;
                        state_q  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        xor_q      <= '0;
                        // Only meaningful when LEN >= 1 (DATA path).
                        last_idx_q <= IDX_W'(w_len - 16'd1);
                        if (w_len_too_big) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        xor_q      <= xor_q ^ rx_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: shift_q[7:0]   <= rx_data;
                            2'd1: shift_q[15:8]  <= rx_data;
                            2'd2: shift_q[23:16] <= rx_data;
                            default: begin
                                imem_wdata_q <= {rx_data, shift_q};
                                imem_waddr_q <= w_waddr;
                                imem_we_q    <= 1'b1;
                                word_idx_q   <= word_idx_d;
                                if (word_idx_q == last_idx_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (rx_data == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Directed self-checking bench for imem_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        we_prev   = 1'b0;
    int          we_double = 0;

    imem_loader #(
        .DEPTH_WORDS (256),
        .BASE_ADDR   (32'h0000_0000),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: record every strobe and flag strobes wider than one cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_waddr);
            wd_q.push_back(imem_wdata);
            if (we_prev) we_double++;
        end
        we_prev = imem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_addr0"}, wa_q[0], 32'h0000_0000);
            check({tag, "_data0"}, wd_q[0], 32'h0050_0093);
            check({tag, "_addr1"}, wa_q[1], 32'h0000_0004);
            check({tag, "_data1"}, wd_q[1], 32'h0010_0113);
        end
    endtask

    logic [7:0] frame1 [12];

    initial begin
        frame1 = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50,
                   8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_we",    {31'b0, imem_we},  32'd0);
        check("rst_waddr", imem_waddr,        32'h0000_0000);
        check("rst_wdata", imem_wdata,        32'h0000_0000);
        check("rst_hold",  {31'b0, cpu_hold}, 32'd1);
        check("rst_done",  {31'b0, done},     32'd0);
        check("rst_error", {31'b0, error},    32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'b0, rx_ready}, 32'd1);
        wa_q.delete();
        wd_q.delete();

        // ---- case 1: good frame, back to back ----
        for (int i = 0; i < 11; i++) send_byte(frame1[i]);
        check("c1_hold_before_csum", {31'b0, cpu_hold}, 32'd1);
        check("c1_done_before_csum", {31'b0, done},     32'd0);
        send_byte(frame1[11]);
        check("c1_done",  {31'b0, done},     32'd1);
        check("c1_hold",  {31'b0, cpu_hold}, 32'd0);
        check("c1_ready", {31'b0, rx_ready}, 32'd0);
        check("c1_error", {31'b0, error},    32'd0);
        tick();
        check_writes("c1");

        // ---- case 2: bad checksum ----
        do_reset();
        for (int i = 0; i < 11; i++) send_byte(frame1[i]);
        send_byte(8'hC0);
        check("c2_error", {31'b0, error},    32'd1);
        check("c2_done",  {31'b0, done},     32'd0);
        check("c2_hold",  {31'b0, cpu_hold}, 32'd1);
        check("c2_ready", {31'b0, rx_ready}, 32'd0);
        tick();
        check_writes("c2");

        // ---- case 3: LEN = 257 > DEPTH_WORDS ----
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        check("c3_error_early", {31'b0, error}, 32'd0);
        send_byte(8'h01);
        check("c3_error", {31'b0, error},    32'd1);
        check("c3_ready", {31'b0, rx_ready}, 32'd0);
        for (int i = 0; i < 6; i++) send_byte(8'h55);
        check("c3_nwrites", 32'(wa_q.size()), 32'd0);
        check("c3_error_hold", {31'b0, error}, 32'd1);
        check("c3_cpu_hold",   {31'b0, cpu_hold}, 32'd1);

        // ---- case 4: junk then empty frame ----
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("c4_junk_done", {31'b0, done},     32'd0);
        check("c4_junk_err",  {31'b0, error},    32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
        check("c4_done",    {31'b0, done},     32'd1);
        check("c4_hold",    {31'b0, cpu_hold}, 32'd0);
        check("c4_nwrites", 32'(wa_q.size()),  32'd0);

        // ---- case 5: reset mid-frame, then a good frame ----
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(frame1[i]);
        do_reset();
        tick();
        check("c5_nwrites_rst", 32'(wa_q.size()),  32'd0);
        check("c5_hold",        {31'b0, cpu_hold}, 32'd1);
        check("c5_ready",       {31'b0, rx_ready}, 32'd1);
        check("c5_wdata",       imem_wdata,        32'h0000_0000);
        for (int i = 0; i < 12; i++) send_byte(frame1[i]);
        tick();
        check("c5_done", {31'b0, done}, 32'd1);
        check_writes("c5");

        // ---- case 6: reload from DONE with a byte offered, then gapped frame ----
        wa_q.delete();
        wd_q.delete();
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        reload   = 1'b0;
        rx_valid = 1'b0;
        check("c6_hold",  {31'b0, cpu_hold}, 32'd1);
        check("c6_done",  {31'b0, done},     32'd0);
        check("c6_ready", {31'b0, rx_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            send_byte(frame1[i]);
        end
        tick();
        check("c6_done_end",  {31'b0, done},     32'd1);
        check("c6_hold_end",  {31'b0, cpu_hold}, 32'd0);
        check("c6_error_end", {31'b0, error},    32'd0);
        check_writes("c6");

        check("we_single_cycle", 32'(we_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
